// File: rtl/update_line_unpacker_if.sv
// Handshake bundle for update_line_unpacker: control, DRAM read line channel,
// and the one-update-per-cycle output stream.
interface update_line_unpacker_if #(
    parameter int DATA_W     = 32,
    parameter int PAR_NUM_W  = 4,
    parameter int LINE_CNT_W = 32
);
    logic                  start;
    logic [PAR_NUM_W-1:0]  par_id;
    logic [LINE_CNT_W-1:0] num_lines;
    logic [511:0]          dram_r;
    logic                  dram_r_valid;
    logic                  dram_r_ready;
    logic [DATA_W-1:0]     upd_dest_vid;
    logic [DATA_W-1:0]     upd_value;
    logic                  upd_valid;
    logic                  upd_ready;
    logic                  busy;
    logic                  done;
    logic                  bin_err;

    modport master (
        output start, par_id, num_lines, dram_r, dram_r_valid, upd_ready,
        input  dram_r_ready, upd_dest_vid, upd_value, upd_valid,
        input  busy, done, bin_err
    );

    modport slave (
        input  start, par_id, num_lines, dram_r, dram_r_valid, upd_ready,
        output dram_r_ready, upd_dest_vid, upd_value, upd_valid,
        output busy, done, bin_err
    );
endinterface

// File: rtl/update_line_unpacker.sv
// Serialises 512-bit partition-bin read lines into a one-update-per-cycle stream.
// Optional bin-id check on every non-pad word: define UNPACK_BIN_CHECK_EN.
module update_line_unpacker #(
    parameter int DATA_W     = 32,
    parameter int PAR_SIZE_W = 17,
    parameter int PAR_NUM_W  = 4,
    parameter int LINE_CNT_W = 32
) (
    input logic clk,
    input logic rst,
    update_line_unpacker_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam int WORD_W = 2 * DATA_W;

    logic [0:0]            state;
    logic [511:0]          line_q;
    logic                  full;
    logic [2:0]            idx;
    logic [LINE_CNT_W-1:0] lines_acc;
    logic [LINE_CNT_W-1:0] num_q;
    logic [PAR_NUM_W-1:0]  par_q;
    logic                  zero_done;

    logic [WORD_W-1:0]     word;
    logic [PAR_NUM_W-1:0]  bin;
    logic run, is_pad, bad_bin, drop, leave, more, accept, finish;

    assign run    = (state == S_RUN);
    // idx 0 selects the oldest word, which sits in the top 64 bits
    assign word   = line_q[int'(~idx) * WORD_W +: WORD_W];
    assign bin    = word[PAR_SIZE_W +: PAR_NUM_W];
    assign is_pad = (word == '0);

`ifdef UNPACK_BIN_CHECK_EN
    logic bin_err_q;

    assign bad_bin     = !is_pad && (bin != par_q);
    assign bus.bin_err = bin_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_err_q <= 1'b0;
        end else if (!run && bus.start) begin
            bin_err_q <= 1'b0;
        end else if (full && bad_bin) begin
            bin_err_q <= 1'b1;
        end
    end
`else
    logic unused_bin;

    assign bad_bin     = 1'b0;
    assign unused_bin  = ^{bin, par_q};
    assign bus.bin_err = 1'b0;
`endif

    assign drop   = is_pad | bad_bin;
    assign leave  = full & (drop | bus.upd_ready);
    assign more   = (lines_acc != num_q);
    assign finish = run & !more & !full;

    // refill when empty, or when the last word drains this cycle
    assign bus.dram_r_ready = run & more & (!full | ((idx == 3'd7) & leave));
    assign accept = bus.dram_r_valid & bus.dram_r_ready;

    assign bus.upd_valid    = full & !drop;
    assign bus.upd_dest_vid = bus.upd_valid ? word[DATA_W-1:0] : '0;
    assign bus.upd_value    = bus.upd_valid ? word[WORD_W-1:DATA_W] : '0;
    assign bus.busy         = run;
    assign bus.done         = finish | zero_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            line_q    <= '0;
            full      <= 1'b0;
            idx       <= '0;
            lines_acc <= '0;
            num_q     <= '0;
            par_q     <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        par_q     <= bus.par_id;
                        num_q     <= bus.num_lines;
                        lines_acc <= '0;
                        if (bus.num_lines != '0) begin
                            state <= S_RUN;
                        end else begin
                            zero_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (finish) begin
                        state <= S_IDLE;
                    end
                end
            endcase

            if (accept) begin
                line_q    <= bus.dram_r;
                full      <= 1'b1;
                idx       <= '0;
                lines_acc <= lines_acc + LINE_CNT_W'(1);
            end else if (leave) begin
                idx <= idx + 3'd1;
                if (idx == 3'd7) begin
                    full <= 1'b0;
                end
            end
        end
    end
endmodule
